// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM encoding,
// parameter limits and the index-width helper.
package bus_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int N_MASTERS_MIN   = 2;
  localparam int N_MASTERS_MAX   = 8;
  localparam int DATA_W_MIN      = 1;
  localparam int DATA_W_MAX      = 8;
  localparam int HOLD_CYCLES_MIN = 1;
  localparam int HOLD_CYCLES_MAX = 15;

  // Index width for n items, never below one bit.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/bus_master_chan.sv
// One master channel: rising-edge request detect plus the pending flag and
// the captured data word.
module bus_master_chan #(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [DATA_W-1:0] data,
  input  logic              clr,
  output logic              pending,
  output logic [DATA_W-1:0] word
);

  logic req_d_r;
  logic edge_s;

  assign edge_s = req & ~req_d_r;

  // A new edge beats a same-cycle grant clear; edges while pending are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_d_r <= 1'b0;
      pending <= 1'b0;
      word    <= '0;
    end else begin
      req_d_r <= req;
      if (edge_s && (!pending || clr)) begin
        pending <= 1'b1;
        word    <= data;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// N-master bus front-end and arbiter: grants one pending channel at a time
// (rotating or fixed priority) onto a registered shared output.
module rr_bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_MASTERS   = 3,
  parameter int DATA_W      = 2,
  parameter int HOLD_CYCLES = 1,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_MASTERS-1:0]            req_in,
  input  logic [N_MASTERS*DATA_W-1:0]     data_in,
  output logic [N_MASTERS-1:0]            ack,
  output logic [N_MASTERS-1:0]            busy,
  output logic [DATA_W-1:0]               data_out,
  output logic [clog2_w(N_MASTERS)-1:0]   grant_id,
  output logic                            data_valid
);

  localparam int ID_W = clog2_w(N_MASTERS);
  localparam int IW1  = ID_W + 1;

  logic [N_MASTERS-1:0] pending_s;
  logic [N_MASTERS-1:0] clr_s;
  logic [N_MASTERS-1:0] onehot_s;
  logic [DATA_W-1:0]    word_s [N_MASTERS];
  logic [0:0]           state_r;
  logic [ID_W-1:0]      ptr_r;
  logic [3:0]           cnt_r;
  logic [ID_W-1:0]      win_s;
  logic                 found_s;
  logic [IW1-1:0]       idx_s;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_chan
    bus_master_chan #(.DATA_W(DATA_W)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .req     (req_in[i]),
      .data    (data_in[i*DATA_W +: DATA_W]),
      .clr     (clr_s[i]),
      .pending (pending_s[i]),
      .word    (word_s[i])
    );
  end

  assign busy = pending_s;

  // Winner search: first pending index from the pointer, wrapping cyclically.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int off = 0; off < N_MASTERS; off++) begin
      if (ROUND_ROBIN != 0) begin
        idx_s = {1'b0, ptr_r} + IW1'(off);
      end else begin
        idx_s = IW1'(off);
      end
      if (idx_s >= IW1'(N_MASTERS)) begin
        idx_s = idx_s - IW1'(N_MASTERS);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && pending_s[idx_s[ID_W-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[ID_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign onehot_s = {{(N_MASTERS-1){1'b0}}, 1'b1} << win_s;

  // Grant-side clear of the winning channel's pending flag.
  always_comb begin
    clr_s = '0;
    if (state_r == ST_IDLE && found_s) begin
      clr_s = onehot_s;
    end else begin
      clr_s = '0;
    end
  end

  // Arbiter FSM with hold counter, priority pointer and registered bus outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      cnt_r      <= 4'd0;
      ack        <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
      grant_id   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            ack        <= onehot_s;
            data_valid <= 1'b1;
            data_out   <= word_s[win_s];
            grant_id   <= win_s;
            cnt_r      <= 4'(HOLD_CYCLES - 1);
            state_r    <= ST_GRANT;
            if (ROUND_ROBIN != 0) begin
              ptr_r <= (win_s == ID_W'(N_MASTERS - 1)) ? '0 : win_s + ID_W'(1);
            end else begin
              ptr_r <= '0;
            end
          end else begin
            ack        <= '0;
            data_valid <= 1'b0;
          end
        end
        ST_GRANT: begin
          ack        <= '0;
          data_valid <= 1'b0;
          if (cnt_r == 4'd0) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          ack        <= '0;
          data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench: three arbiter instances (round-robin, fixed priority,
// long hold); expected grants are queued at stimulus time and popped on ack.
module tb_rr_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic [2:0] req_a, req_b, req_c;
  logic [5:0] d_a, d_b, d_c;
  logic [2:0] ack_a, ack_b, ack_c, busy_a, busy_b, busy_c;
  logic [1:0] dout_a, dout_b, dout_c, gid_a, gid_b, gid_c;
  logic       dv_a, dv_b, dv_c;

  typedef struct {
    logic [2:0] ack;
    logic [1:0] data;
    logic [1:0] gid;
    int         cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rr_bus_arbiter #(.N_MASTERS(3), .DATA_W(2), .HOLD_CYCLES(1), .ROUND_ROBIN(1)) dut_a (
    .clk(clk), .reset(rst_a), .req_in(req_a), .data_in(d_a), .ack(ack_a),
    .busy(busy_a), .data_out(dout_a), .grant_id(gid_a), .data_valid(dv_a));
  rr_bus_arbiter #(.N_MASTERS(3), .DATA_W(2), .HOLD_CYCLES(1), .ROUND_ROBIN(0)) dut_b (
    .clk(clk), .reset(rst_b), .req_in(req_b), .data_in(d_b), .ack(ack_b),
    .busy(busy_b), .data_out(dout_b), .grant_id(gid_b), .data_valid(dv_b));
  rr_bus_arbiter #(.N_MASTERS(3), .DATA_W(2), .HOLD_CYCLES(3), .ROUND_ROBIN(1)) dut_c (
    .clk(clk), .reset(rst_c), .req_in(req_c), .data_in(d_c), .ack(ack_c),
    .busy(busy_c), .data_out(dout_c), .grant_id(gid_c), .data_valid(dv_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int ch, input logic [1:0] d, input int c);
    exp_t e;
    e.ack  = 3'(1 << ch);
    e.data = d;
    e.gid  = 2'(ch);
    e.cyc  = c;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (ack_a != 3'b000 || dv_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_ack", {29'd0, ack_a}, 32'd0);
      end else begin
        e = qa.pop_front();
        check("a_ack", {29'd0, ack_a}, {29'd0, e.ack});
        check("a_dv", {31'd0, dv_a}, 32'd1);
        check("a_data", {30'd0, dout_a}, {30'd0, e.data});
        check("a_gid", {30'd0, gid_a}, {30'd0, e.gid});
        check("a_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (ack_b != 3'b000 || dv_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_ack", {29'd0, ack_b}, 32'd0);
      end else begin
        e = qb.pop_front();
        check("b_ack", {29'd0, ack_b}, {29'd0, e.ack});
        check("b_dv", {31'd0, dv_b}, 32'd1);
        check("b_data", {30'd0, dout_b}, {30'd0, e.data});
        check("b_gid", {30'd0, gid_b}, {30'd0, e.gid});
        check("b_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (ack_c != 3'b000 || dv_c) begin
      if (qc.size() == 0) begin
        check("c_unexpected_ack", {29'd0, ack_c}, 32'd0);
      end else begin
        e = qc.pop_front();
        check("c_ack", {29'd0, ack_c}, {29'd0, e.ack});
        check("c_dv", {31'd0, dv_c}, 32'd1);
        check("c_data", {30'd0, dout_c}, {30'd0, e.data});
        check("c_gid", {30'd0, gid_c}, {30'd0, e.gid});
        check("c_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    req_a = 3'b000; req_b = 3'b000; req_c = 3'b000;
    d_a = 6'd0; d_b = 6'd0; d_c = 6'd0;
    repeat (2) tick();
    check("rst_ack", {29'd0, ack_a}, 32'd0);
    check("rst_busy", {29'd0, busy_a}, 32'd0);
    check("rst_data", {30'd0, dout_a}, 32'd0);
    check("rst_gid", {30'd0, gid_a}, 32'd0);
    check("rst_dv", {31'd0, dv_a}, 32'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick();

    // single request: two-cycle latency
    d_a = 6'b00_00_10;
    req_a = 3'b001;
    tick();
    check("t1_busy_set", {29'd0, busy_a}, 32'd1);
    qa.push_back(mk(0, 2'b10, cyc + 1));
    tick();
    check("t1_busy_clr", {29'd0, busy_a}, 32'd0);
    check("t1_dout", {30'd0, dout_a}, 32'd2);
    req_a = 3'b000;
    tick();

    // round-robin ordering after ch1 moves the pointer to 2
    req_a = 3'b010;
    tick();
    qa.push_back(mk(1, 2'b00, cyc + 1));
    tick();
    req_a = 3'b000;
    tick();
    d_a = 6'b11_10_01;
    req_a = 3'b111;
    tick();
    check("t2_busy_all", {29'd0, busy_a}, 32'd7);
    qa.push_back(mk(2, 2'b11, cyc + 1));
    qa.push_back(mk(0, 2'b01, cyc + 3));
    qa.push_back(mk(1, 2'b10, cyc + 5));
    repeat (6) tick();
    check("t2_busy_done", {29'd0, busy_a}, 32'd0);
    check("t2_dout_hold", {30'd0, dout_a}, 32'd2);
    req_a = 3'b000;
    tick();

    // re-request while pending keeps the first word
    d_a = 6'b00_01_00;
    req_a = 3'b011;
    tick();
    qa.push_back(mk(0, 2'b00, cyc + 1));
    qa.push_back(mk(1, 2'b01, cyc + 3));
    req_a = 3'b001;
    tick();
    req_a = 3'b011;
    d_a[3:2] = 2'b11;
    tick();
    check("t4_busy_pend", {29'd0, busy_a}, 32'd2);
    tick();
    check("t4_busy_clr", {29'd0, busy_a}, 32'd0);
    req_a = 3'b000;
    repeat (2) tick();

    // reset mid-grant with ch2 pending
    d_a[3:2] = 2'b10;
    req_a = 3'b010;
    tick();
    qa.push_back(mk(1, 2'b10, cyc + 1));
    req_a = 3'b110;
    tick();
    check("t5_ch2_pend", {29'd0, busy_a}, 32'd4);
    @(negedge clk);
    #1;
    rst_a = 1'b0;
    req_a = 3'b000;
    #1;
    check("t5_ack0", {29'd0, ack_a}, 32'd0);
    check("t5_busy0", {29'd0, busy_a}, 32'd0);
    check("t5_dout0", {30'd0, dout_a}, 32'd0);
    check("t5_gid0", {30'd0, gid_a}, 32'd0);
    check("t5_dv0", {31'd0, dv_a}, 32'd0);
    repeat (2) tick();
    rst_a = 1'b1;
    repeat (8) tick();
    check("t5_busy_after", {29'd0, busy_a}, 32'd0);

    // fixed priority: ch0 keeps winning while it re-requests
    d_b = 6'b11_00_01;
    req_b = 3'b101;
    tick();
    qb.push_back(mk(0, 2'b01, cyc + 1));
    req_b = 3'b100;
    tick();
    d_b[1:0] = 2'b10;
    req_b = 3'b101;
    tick();
    qb.push_back(mk(0, 2'b10, cyc + 1));
    req_b = 3'b100;
    tick();
    d_b[1:0] = 2'b00;
    req_b = 3'b101;
    tick();
    qb.push_back(mk(0, 2'b00, cyc + 1));
    req_b = 3'b100;
    tick();
    qb.push_back(mk(2, 2'b11, cyc + 2));
    repeat (4) tick();
    req_b = 3'b000;
    tick();

    // long hold: grants four cycles apart
    d_c = 6'b11_10_01;
    req_c = 3'b111;
    tick();
    qc.push_back(mk(0, 2'b01, cyc + 1));
    qc.push_back(mk(1, 2'b10, cyc + 5));
    qc.push_back(mk(2, 2'b11, cyc + 9));
    repeat (10) tick();
    req_c = 3'b000;
    repeat (2) tick();

    check("qa_left", qa.size(), 32'd0);
    check("qb_left", qb.size(), 32'd0);
    check("qc_left", qc.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Parametrised N-master bus front-end and arbiter. Each master channel latches a request and its data word on a rising `req_in` edge. A shared arbiter (round-robin or fixed priority) grants one pending channel at a time, drives the granted word onto a single registered bus output, and returns a one-cycle acknowledge to the winner. The block sits between the board request/data inputs and the display decoder, and succeeds the fixed three-master bus arrangement.

## Interface
- `N_MASTERS`, 3: number of master channels, 2..8
- `DATA_W`, 2: data word width per master, 1..8
- `HOLD_CYCLES`, 1: cycles the bus stays in GRANT per transfer, 1..15
- `ROUND_ROBIN`, 1: 1 = rotating priority; 0 = fixed priority, lowest index wins
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_in`  in  N_MASTERS  per-master request level; only a rising edge registers a request
- `data_in`  in  N_MASTERS*DATA_W  packed data; master i at [i*DATA_W +: DATA_W]
- `ack`  out  N_MASTERS  one-hot, one-cycle pulse when master i's transfer is granted
- `busy`  out  N_MASTERS  master i holds a pending, ungranted request
- `data_out`  out  DATA_W  data of the last granted transfer, held until the next grant
- `grant_id`  out  clog2(N_MASTERS)  index of the last granted master
- `data_valid`  out  1  one-cycle pulse, coincident with `ack`

## Operation
- Reset (`reset`=0) asynchronously clears all registers:
  - `ack`, `busy`, `data_out`, `grant_id`, `data_valid` = 0
  - priority pointer = 0, FSM = IDLE
  - registered `req_in` copy = 0, hold counter = 0
- Channel front-end, per master i:
  - edge_i = `req_in[i]` & ~req_d[i], where req_d is `req_in` registered each cycle.
  - On an edge with pending_i = 0: pending_i <= 1, word_i <= data_in slice i.
  - An edge while pending_i = 1 is dropped; word_i keeps its original value.
  - If grant clears pending_i in the same cycle as a new edge on i, the set wins: the new word is captured and pending_i stays 1.
  - `busy` = pending vector, registered.
- Arbiter FSM:
  - IDLE: if any pending, select winner w, then:
    - `ack` <= onehot(w), `data_valid` <= 1
    - `data_out` <= word_w, `grant_id` <= w
    - clear pending_w, load hold counter = HOLD_CYCLES-1, go GRANT
    - If nothing is pending, stay in IDLE with `ack`/`data_valid` = 0.
  - GRANT: `ack`/`data_valid` = 0; decrement the counter; at 0, go IDLE.
- Winner selection:
  - ROUND_ROBIN=1: first pending index at or above the pointer, searching cyclically (wrapping N_MASTERS-1 -> 0); after each grant, pointer <= (w+1) mod N_MASTERS.
  - ROUND_ROBIN=0: lowest pending index; the pointer is unused and stays 0.
- `data_out`/`grant_id` are not cleared on return to IDLE.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Request latency:
  - `req_in[i]` rises and is sampled at edge k; pending/`busy[i]` are high after edge k.
  - With the FSM in IDLE at edge k+1, `ack[i]`, `data_valid` and the new `data_out` appear after edge k+1 (2 cycles); `busy[i]` falls at the same edge.
- Throughput: one grant per HOLD_CYCLES+1 cycles under continuous load.
- `req_in` already high when reset is released counts as a rising edge on the first clock.
- Reset asserted mid-GRANT forces the outputs to 0 immediately and discards all pending words; no ack follows release unless a new edge occurs.

## Structure
- Package `bus_pkg`:
  - FSM state encoding (IDLE, GRANT)
  - clog2 width function
  - parameter range limits
- Sub-module `bus_master_chan`: edge detect plus the pending/word register for one channel, instantiated N_MASTERS times in a generate loop.
- The arbiter FSM, pointer and hold counter live in `rr_bus_arbiter`.
- The display decoder stays outside the block and consumes `data_out`.

## Test plan
All tests use N_MASTERS=3, DATA_W=2, HOLD_CYCLES=1, ROUND_ROBIN=1 unless noted.
1. Single request: ch0 data=2'b10, `req_in`=001 rises at edge 1 -> `busy`=001 after edge 1; `ack`=001, `data_valid`=1, `data_out`=10, `grant_id`=0 after edge 2; `busy`=000.
2. Round-robin ordering: ch1 granted first (pointer -> 2), then ch0/ch1/ch2 rise together (data 01/10/11) -> grant order is ch2, ch0, ch1, with acks 2 cycles apart and `data_out` 11, 01, 10.
3. Fixed priority (ROUND_ROBIN=0): ch0 and ch2 pending, ch0 re-requests right after each ack -> ch0 wins every arbitration while it stays pending; ch2 is granted only once ch0 stops.
4. Re-request while pending: ch1 captures 2'b01, drops `req_in`, then rises again with 2'b11 before its grant -> granted `data_out`=01.
5. Reset mid-GRANT: `reset`=0 during GRANT with ch2 pending -> all outputs 0 immediately; after release with `req_in` held low, no `ack` ever.
6. HOLD_CYCLES=3, all three channels pending -> acks 4 cycles apart; no `ack` during hold cycles.
